mps_lbus_axi_master: RTL
========================

Name: mps_lbus_axi_master

Overview:
- Upstream neighbour of the multi-port serial block.
- Converts single-beat host-side local-bus register requests (from the PCI target decode) into AXI4-Lite master transactions on the serial block's register-space port.
- Returns read data or completion status to the host side.
- One outstanding transaction at a time; strict in-order completion.

Parameters:
- ADDR_WIDTH, 32, width of the local-bus and AXI address.
- TIMEOUT_CYCLES, 1024, aclk cycles allowed from request acceptance to AXI response before an abort (used only with the optional feature).

Ports:
- aclk  in  1  system clock; all logic is on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables, mapped to wstrb.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data; 0 for writes.
- resp_err  out  1  AXI SLVERR/DECERR or timeout.
- m_axi_awaddr  out  ADDR_WIDTH
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  32
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset values: all valid/ready outputs 0 except req_ready = 1; resp_rdata, resp_err, awaddr, araddr, wdata and wstrb are 0; state is IDLE.
- States: IDLE, WADDR (AW and W issued concurrently), WRESP, RADDR, RDATA, DONE.
- IDLE: req_ready = 1. On req_valid & req_ready:
  - Register addr, wdata and be.
  - Deassert req_ready next cycle.
  - Go to WADDR if req_we, else RADDR.
  - Next cycle, awvalid and wvalid (write) or arvalid (read) assert.
- WADDR:
  - awvalid drops the cycle after awready is sampled high; wvalid likewise with wready.
  - The two handshakes complete independently, in either order or in the same cycle; per-channel done flags track them.
  - When both are done, go to WRESP.
  - Valids never drop before their ready.
- WRESP: bready = 1. On bvalid, capture resp_err = (bresp != 0) and go to DONE.
- RADDR: hold arvalid until arready, then go to RDATA.
- RDATA: rready = 1. On rvalid, capture rdata and resp_err = (rresp != 0), then go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then return to IDLE with req_ready = 1.
  - Minimum host-visible latency, request accept to resp_valid: 4 cycles for a read with zero-wait slave, 4 cycles for a write.
- Address, data and strobe outputs are stable while their valid is high.
- A request presented while req_ready = 0 is ignored; the host must hold it.
- Asynchronous reset mid-transaction returns to IDLE immediately. No resp_valid is issued for the aborted request; AXI valids drop.

Optional Feature:
- Macro: MPS_LBUS_TIMEOUT_EN.
- Defined:
  - A counter clears on request accept and increments in WADDR/WRESP/RADDR/RDATA.
  - On reaching TIMEOUT_CYCLES-1 the bridge goes to DONE with resp_err = 1 and resp_rdata = 32'hFFFF_FFFF.
  - All AXI valids and readies deassert.
  - A late bvalid/rvalid arriving after an abort is accepted (one-cycle bready/rready) and discarded, and does not generate resp_valid.
- Undefined: no counter; the bridge waits indefinitely.

Decomposition:
- Shared package mps_pkg:
  - State enum.
  - AXI response constants: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - Abort data constant 32'hFFFF_FFFF.
- Sub-module mps_lbus_timeout: loadable counter with expiry flag, instantiated only under the macro.

Test Plan:
- Write addr 0x0000_0010, data 0xA5, be 4'b0001; slave asserts awready and wready in the same cycle, bresp OKAY → awaddr=0x10, wstrb=0001, one resp_valid, resp_err=0, resp_rdata=0.
- Write where wready arrives 3 cycles before awready → wvalid drops after its handshake, awvalid held; single B accepted; resp_err=0.
- Read addr 0x14; slave returns rdata 0x0000_0060 after 2 wait cycles → resp_rdata=0x60, resp_err=0, req_ready low throughout.
- Read with rresp=SLVERR and rdata 0x1234 → resp_err=1, resp_rdata=0x1234.
- Back-to-back requests held on req_valid → second accepted only after the first resp_valid; no overlap on AXI.
- With MPS_LBUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready → resp_valid 16 cycles after accept, resp_err=1, rdata=0xFFFF_FFFF. Separately, assert aresetn=0 mid-WRESP → all outputs at reset values, no resp_valid.

Source files
------------

// File: rtl/mps_pkg.sv
// Shared types and constants for the local-bus to AXI4-Lite master bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mps_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WADDR = 3'd1,   // AW and W outstanding together
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [1:0]  AXI_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_SLVERR = 2'b10;
   localparam logic [1:0]  AXI_DECERR = 2'b11;

   // Read data returned to the host when a transaction is aborted.
   localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

   // Anything other than OKAY (including EXOKAY, which AXI4-Lite never
   // legitimately returns) is reported to the host as an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_OKAY;
   endfunction

endpackage

// File: rtl/mps_lbus_timeout.sv
// Transaction watchdog: loadable up-counter that flags expiry.
// Latency: expire_o asserts combinationally in the cycle the count steps to LIMIT-1.
// Backpressure: none; counts every cycle en_i is high.
//
// Ports:
//   aclk, aresetn  clock / async active-low reset
//   clr_i          clear count to 0 (request accept)
//   en_i           count enable (transaction in flight)
//   expire_o       high while enabled and the count is about to reach LIMIT-1
module mps_lbus_timeout #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(LIMIT) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Expiry is flagged on the step to LIMIT-1 so the state machine moves to
   // its completion state in the same edge the counter gets there.
   assign expire_o = en_i && (cnt_q == CW'(LIMIT - 2));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mps_lbus_axi_master.sv
// Local-bus register request -> single AXI4-Lite master transaction bridge.
// Latency: accept to resp_valid is 3 edges with a zero-wait slave (resp_valid in the 4th cycle).
// Backpressure: req_ready low from accept until the completion pulse; one transaction in flight.
//
// Ports: aclk/aresetn clock and async active-low reset; req_* host request
// (valid/ready, we, addr, wdata, be); resp_* one-cycle completion with rdata/err;
// m_axi_* AXI4-Lite master (AW, W, B, AR, R channels).
// Optional build macro MPS_LBUS_TIMEOUT_EN: abort with resp_err=1 and all-ones
// read data after TIMEOUT_CYCLES in flight; late B/R responses are drained.
module mps_lbus_axi_master #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_be,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   import mps_pkg::*;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  accept;
   logic                  busy;
   logic                  to_expire;
   logic                  drain_b_q, drain_b_d;
   logic                  drain_r_q, drain_r_d;

   assign busy = (state_q == ST_WADDR) || (state_q == ST_WRESP) ||
                 (state_q == ST_RADDR) || (state_q == ST_RDATA);

`ifdef MPS_LBUS_TIMEOUT_EN
   mps_lbus_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .clr_i    (accept),
      .en_i     (busy),
      .expire_o (to_expire)
   );
`else
   assign to_expire = 1'b0;
`endif

   // Outputs are decoded from registered state only, so address/data/strobe
   // are held from the accept edge and cannot move while a valid is up.
   assign req_ready     = (state_q == ST_IDLE);
   assign resp_valid    = (state_q == ST_DONE);
   assign resp_rdata    = rdata_q;
   assign resp_err      = err_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = be_q;
   assign m_axi_awvalid = (state_q == ST_WADDR) && !aw_done_q;
   assign m_axi_wvalid  = (state_q == ST_WADDR) && !w_done_q;
   assign m_axi_arvalid = (state_q == ST_RADDR);
   // A response that straggles in after an abort is taken for one cycle
   // and thrown away so the slave is not left stalled.
   assign m_axi_bready  = (state_q == ST_WRESP) || (drain_b_q && m_axi_bvalid);
   assign m_axi_rready  = (state_q == ST_RDATA) || (drain_r_q && m_axi_rvalid);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      accept    = 1'b0;
      drain_b_d = drain_b_q && !m_axi_bvalid;
      drain_r_d = drain_r_q && !m_axi_rvalid;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               be_d      = req_be;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b0;
               state_d   = req_we ? ST_WADDR : ST_RADDR;
            end
         end
         ST_WADDR: begin
            // Ready while our valid is already retired is harmless: the
            // flag is simply set again.
            if (m_axi_awready) aw_done_d = 1'b1;
            if (m_axi_wready)  w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = ST_WRESP;
         end
         ST_WRESP: begin
            if (m_axi_bvalid) begin
               err_d   = resp_is_err(m_axi_bresp);
               state_d = ST_DONE;
            end
         end
         ST_RADDR: begin
            if (m_axi_arready) state_d = ST_RDATA;
         end
         ST_RDATA: begin
            if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               err_d   = resp_is_err(m_axi_rresp);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (to_expire) begin
         state_d = ST_DONE;
         err_d   = 1'b1;
         rdata_d = ABORT_DATA;
         // Only expect a late response if the request reached the slave and
         // the response was not consumed in this very cycle.
         if (state_q == ST_WRESP && !m_axi_bvalid) drain_b_d = 1'b1;
         if (state_q == ST_RDATA && !m_axi_rvalid) drain_r_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         drain_b_q <= 1'b0;
         drain_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         drain_b_q <= drain_b_d;
         drain_r_q <= drain_r_d;
      end
   end

endmodule
